// File: rtl/uart_flow_sched.sv
// uart_flow_sched: XON/XOFF scheduler choosing control or FIFO data bytes for the UART transmitter.
// Ports: clk/rst (async, active-high); en enables flow control; rx_free is the RX FIFO free count;
// fifo_empty/fifo_data/fifo_rd_en form the show-ahead TX FIFO read port; peer_byte_valid/peer_byte
// carry received bytes, and peer_ctrl flags XON/XOFF among them; out_valid/out_data/out_ready
// connect to the transmitter; local_stopped/peer_stopped report the flow-control state.
module uart_flow_sched #(
  parameter int DEPTH = 16,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int XOFF_THRESH = 4,
  parameter int XON_THRESH = 8,
  parameter logic [7:0] XON_CHAR = 8'h11,
  parameter logic [7:0] XOFF_CHAR = 8'h13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ADDR_BITS:0]   rx_free,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_data,
  output logic                 fifo_rd_en,
  input  logic                 peer_byte_valid,
  input  logic [7:0]           peer_byte,
  output logic                 peer_ctrl,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic                 local_stopped,
  output logic                 peer_stopped
);
  localparam int W = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] XOFF_L = W'(XOFF_THRESH);
  localparam logic [ADDR_BITS:0] XON_L = W'(XON_THRESH);
  if (!(XOFF_THRESH >= 0 && XOFF_THRESH < XON_THRESH && XON_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("uart_flow_sched: thresholds must satisfy 0 <= XOFF_THRESH < XON_THRESH <= DEPTH");
  end
  typedef enum logic [1:0] {IDLE, SEND_CTRL, SEND_DATA} state_t;
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, local_stopped_q, local_stopped_d, peer_stopped_q, peer_stopped_d;
  logic [7:0] out_data_q, out_data_d;
  logic need_xoff, need_xon, pop;
  assign need_xoff = en & ~local_stopped_q & (rx_free <= XOFF_L);
  assign need_xon = en & local_stopped_q & (rx_free >= XON_L);
  assign peer_ctrl = en & peer_byte_valid & (peer_byte == XON_CHAR | peer_byte == XOFF_CHAR);
  // The pop is combinational so the show-ahead head is captured in the same cycle it is consumed.
  assign fifo_rd_en = pop & ~rst;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign local_stopped = local_stopped_q;
  assign peer_stopped = peer_stopped_q;
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    local_stopped_d = local_stopped_q;
    peer_stopped_d = peer_ctrl ? (peer_byte == XOFF_CHAR) : peer_stopped_q;
    pop = 1'b0;
    if (state_q == IDLE) begin
      if (need_xoff | need_xon) begin
        out_data_d = need_xoff ? XOFF_CHAR : XON_CHAR;
        out_valid_d = 1'b1;
        state_d = SEND_CTRL;
      end else if (~fifo_empty & ~peer_stopped_q) begin
        pop = 1'b1;
        out_data_d = fifo_data;
        out_valid_d = 1'b1;
        state_d = SEND_DATA;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
      // Only a completed control handshake moves local_stopped; the held byte says which one it was.
      if (state_q == SEND_CTRL) local_stopped_d = (out_data_q == XOFF_CHAR);
    end
    if (!en) begin
      local_stopped_d = 1'b0;
      peer_stopped_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q <= 8'h00;
      local_stopped_q <= 1'b0;
      peer_stopped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      local_stopped_q <= local_stopped_d;
      peer_stopped_q <= peer_stopped_d;
    end
  end
endmodule
